// File: rtl/irq_arbiter_pkg.sv
// Shared types and default sizing for the multi-source interrupt arbiter.
package irq_pkg;

  localparam int DEF_NUM_SRC      = 4;
  localparam int DEF_PULSE_CYCLES = 6;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_ASSERT,
    IRQ_WAIT_ACK
  } irq_state_t;

endpackage

// File: rtl/irq_arbiter_if.sv
// Request/mask/status bundle between the interrupt sources, the CPU and the arbiter.
interface irq_arbiter_if
  import irq_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int ID_W    = $clog2(NUM_SRC)
);

  logic [NUM_SRC-1:0] src_req;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_wdata;
  logic               int_en;
  logic               ack;
  logic               interrupt;
  logic [ID_W-1:0]    irq_id;
  logic               busy;
  logic [NUM_SRC-1:0] pending;

  modport slave (
    input  src_req, mask_we, mask_wdata, int_en, ack,
    output interrupt, irq_id, busy, pending
  );

  modport master (
    output src_req, mask_we, mask_wdata, int_en, ack,
    input  interrupt, irq_id, busy, pending
  );

endinterface

// File: rtl/irq_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate so the search starts after `last`,
// take the lowest set bit, then rotate the index back.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic [ID_W-1:0] grant_id,
  output logic            any
);

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N - 1);
  localparam logic [ID_W:0]   N_W      = (ID_W + 1)'(N);

  logic [ID_W-1:0] w_start;
  logic [2*N-1:0]  w_dbl;
  logic [N-1:0]    w_rot;
  logic [ID_W-1:0] w_idx;
  logic [ID_W:0]   w_sum;
  logic [ID_W:0]   w_wrap;

  assign any = |req;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_start = (last == LAST_IDX) ? '0 : last + 1'b1;
    w_dbl   = {req, req};
    w_rot   = N'(w_dbl >> w_start);
    w_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_idx = ID_W'(i);
    end
    w_sum    = {1'b0, w_idx} + {1'b0, w_start};
    w_wrap   = w_sum - N_W;
    grant_id = (w_sum >= N_W) ? w_wrap[ID_W-1:0] : w_sum[ID_W-1:0];
  end

endmodule

// File: rtl/irq_arbiter.sv
// Multi-source interrupt arbiter: edge-latched pending bits, per-source mask,
// round-robin grant and a fixed-length interrupt pulse held until the CPU acks.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int NUM_SRC      = DEF_NUM_SRC,
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES
) (
  input logic          CLK,
  input logic          RST_N,
  irq_arbiter_if.slave irq_bus
);

  localparam int ID_W  = $clog2(NUM_SRC);
  localparam int CNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  localparam logic [1:0] S_IDLE     = IRQ_IDLE;
  localparam logic [1:0] S_ASSERT   = IRQ_ASSERT;
  localparam logic [1:0] S_WAIT_ACK = IRQ_WAIT_ACK;

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_src_prev;
  logic [ID_W-1:0]    r_last;
  logic [ID_W-1:0]    r_irq_id;
  logic               r_busy;
  logic               r_int;

  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_elig;
  logic [NUM_SRC-1:0] w_clr;
  logic [ID_W-1:0]    w_win;
  logic               w_any;
  logic               w_grant;

  assign w_rise  = irq_bus.src_req & ~r_src_prev;
  assign w_elig  = r_pending & ~r_mask;
  assign w_grant = (r_state == S_IDLE) && irq_bus.int_en && w_any;
  assign w_clr   = w_grant ? (NUM_SRC'(1) << w_win) : '0;

  rr_pick #(
    .N    (NUM_SRC),
    .ID_W (ID_W)
  ) u_pick (
    .req      (w_elig),
    .last     (r_last),
    .grant_id (w_win),
    .any      (w_any)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_mask     <= '1;
      r_pending  <= '0;
      r_src_prev <= '0;
      r_last     <= ID_W'(NUM_SRC - 1);
      r_irq_id   <= '0;
      r_busy     <= 1'b0;
      r_int      <= 1'b0;
    end else begin
      r_src_prev <= irq_bus.src_req;
      // A rise on the source being granted re-arms it: set wins over clear.
      r_pending  <= (r_pending & ~w_clr) | w_rise;
      if (irq_bus.mask_we) r_mask <= irq_bus.mask_wdata;

      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_irq_id <= w_win;
            r_last   <= w_win;
            r_busy   <= 1'b1;
            r_int    <= 1'b1;
            r_cnt    <= CNT_W'(PULSE_CYCLES - 1);
            r_state  <= S_ASSERT;
          end
        end
        S_ASSERT: begin
          if (r_cnt == '0) begin
            r_int   <= 1'b0;
            r_state <= S_WAIT_ACK;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WAIT_ACK: begin
          if (irq_bus.ack) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign irq_bus.interrupt = r_int;
  assign irq_bus.irq_id    = r_irq_id;
  assign irq_bus.busy      = r_busy;
  assign irq_bus.pending   = r_pending;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed self-checking bench for irq_arbiter (4 sources, 6-cycle pulse).
module tb_irq_arbiter;

  logic CLK;
  logic RST_N;
  int   n_checks;
  int   n_fail;
  int   pulse_len;

  irq_arbiter_if #(.NUM_SRC(4)) bus ();

  irq_arbiter #(
    .NUM_SRC      (4),
    .PULSE_CYCLES (6)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .irq_bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs set and outputs read 1ns after the rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic ack_pulse();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
  endtask

  task automatic wait_int_low(input string tag);
    for (int i = 0; i < 20 && bus.interrupt; i++) tick();
    check(tag, bus.interrupt, 0);
  endtask

  task automatic count_pulse(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.interrupt) break;
      n++;
      tick();
    end
  endtask

  task automatic serve(input logic [1:0] exp_id, input string tag);
    for (int i = 0; i < 20 && !bus.busy; i++) tick();
    check({tag, "_busy"}, bus.busy, 1);
    check({tag, "_id"}, bus.irq_id, exp_id);
    wait_int_low({tag, "_fall"});
    ack_pulse();
    check({tag, "_done"}, bus.busy, 0);
  endtask

  task automatic reset_dut();
    RST_N          = 1'b0;
    bus.src_req    = '0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
    bus.ack        = 1'b0;
    #12;
    RST_N = 1'b1;
    tick();
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    RST_N          = 1'b0;
    bus.src_req    = '0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
    bus.int_en     = 1'b0;
    bus.ack        = 1'b0;
    #12;
    check("rst_int", bus.interrupt, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_pend", bus.pending, 4'b0000);
    check("rst_id", bus.irq_id, 0);
    RST_N = 1'b1;
    tick();

    // Single source, exact pulse length, busy held until ack.
    bus.mask_we    = 1'b1;
    bus.mask_wdata = 4'b0000;
    bus.int_en     = 1'b1;
    tick();
    bus.mask_we = 1'b0;
    bus.src_req = 4'b0100;
    tick();
    check("a_pend", bus.pending, 4'b0100);
    check("a_idle", bus.busy, 0);
    tick();
    check("a_busy", bus.busy, 1);
    check("a_id", bus.irq_id, 2);
    check("a_pend_clr", bus.pending, 4'b0000);
    count_pulse(pulse_len);
    check("a_pulse_len", pulse_len, 6);
    tick(2);
    check("a_hold", bus.busy, 1);
    ack_pulse();
    check("a_ack", bus.busy, 0);
    bus.src_req = '0;

    // Round-robin order from a fresh reset, then wrapping after id 3.
    reset_dut();
    bus.mask_we    = 1'b1;
    bus.mask_wdata = 4'b0000;
    tick();
    bus.mask_we = 1'b0;
    bus.src_req = 4'b1011;
    tick();
    check("b_pend", bus.pending, 4'b1011);
    serve(2'd0, "b1_0");
    serve(2'd1, "b1_1");
    serve(2'd3, "b1_3");
    bus.src_req = 4'b0000;
    tick();
    bus.src_req = 4'b1011;
    tick();
    serve(2'd0, "b2_0");
    serve(2'd1, "b2_1");
    serve(2'd3, "b2_3");
    bus.src_req = 4'b0000;
    tick();

    // Masked source latches pending; unmasking grants it next cycle.
    bus.mask_we    = 1'b1;
    bus.mask_wdata = 4'b0010;
    tick();
    bus.mask_we = 1'b0;
    bus.src_req = 4'b0010;
    tick(3);
    check("c_pend", bus.pending, 4'b0010);
    check("c_noint", bus.interrupt, 0);
    check("c_nobusy", bus.busy, 0);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = 4'b0000;
    tick();
    bus.mask_we = 1'b0;
    check("c_wait", bus.busy, 0);
    tick();
    check("c_busy", bus.busy, 1);
    check("c_id", bus.irq_id, 1);
    wait_int_low("c_fall");
    ack_pulse();
    check("c_ack", bus.busy, 0);

    // Global enable gates grants only; dropping it mid-pulse does not abort.
    bus.int_en  = 1'b0;
    bus.src_req = 4'b1010;
    tick(3);
    check("d_blocked", bus.busy, 0);
    check("d_pend", bus.pending, 4'b1000);
    bus.int_en = 1'b1;
    tick();
    check("d_busy", bus.busy, 1);
    check("d_id", bus.irq_id, 3);
    bus.int_en = 1'b0;
    count_pulse(pulse_len);
    check("d_pulse_len", pulse_len, 6);
    ack_pulse();
    check("d_ack", bus.busy, 0);
    bus.int_en = 1'b1;

    // Early ack ignored; event during WAIT_ACK re-granted after ack.
    bus.src_req = 4'b1011;
    tick();
    check("e_pend", bus.pending, 4'b0001);
    tick();
    check("e_busy", bus.busy, 1);
    check("e_id", bus.irq_id, 0);
    ack_pulse();
    check("e_early_ack", bus.busy, 1);
    wait_int_low("e_fall");
    tick(2);
    check("e_still_busy", bus.busy, 1);
    bus.src_req = 4'b1010;
    tick();
    bus.src_req = 4'b1011;
    tick();
    check("e_repend", bus.pending, 4'b0001);
    ack_pulse();
    check("e_ack", bus.busy, 0);
    tick();
    check("e_regrant", bus.busy, 1);
    check("e_reid", bus.irq_id, 0);
    check("e_reclr", bus.pending, 4'b0000);

    // Async reset in the 3rd pulse cycle; all sources masked afterwards.
    bus.src_req = 4'b1111;
    tick();
    check("f_pend_pre", bus.pending, 4'b0100);
    tick();
    check("f_int_pre", bus.interrupt, 1);
    #2;
    RST_N = 1'b0;
    #1;
    check("f_int_rst", bus.interrupt, 0);
    check("f_busy_rst", bus.busy, 0);
    check("f_pend_rst", bus.pending, 4'b0000);
    #10;
    RST_N = 1'b1;
    tick(3);
    check("f_masked_pend", bus.pending, 4'b1111);
    check("f_masked_busy", bus.busy, 0);
    check("f_masked_int", bus.interrupt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
